// File: rtl/bcd_arb_pkg.sv
// Shared types and defaults for the BCD converter arbiter.
// Holds the one-hot FSM state encoding, default widths and the index-width helper.
package bcd_arb_pkg;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_START     = 5'b00010,
    S_WAIT_ACK  = 5'b00100,
    S_WAIT_DONE = 5'b01000,
    S_CAPTURE   = 5'b10000
  } state_t;

  localparam int DEF_N_REQ       = 2;
  localparam int DEF_IN_WIDTH    = 32;
  localparam int DEF_BCD_WIDTH   = 32;
  localparam int DEF_ACK_TIMEOUT = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping around to the lowest index when none is found above it.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Two passes: upper segment from the pointer first, then the wrapped lower segment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr)) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between N_REQ requesters.
// Keeps one registered BCD result per requester and pulses done on each update.
// Optional feature macro: BCD_ARB_SKIP_UNCHANGED_EN -- when defined, a request whose
// value matches the last converted value for that requester skips the converter.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int BCD_WIDTH   = DEF_BCD_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*IN_WIDTH-1:0]       req_value,
  output logic [N_REQ-1:0]                done,
  output logic [N_REQ*BCD_WIDTH-1:0]      bcd_out,
  output logic                            busy,
  output logic [idx_width(N_REQ)-1:0]     grant_idx,
  output logic                            conv_trigger,
  output logic [IN_WIDTH-1:0]             conv_in,
  input  logic                            conv_idle,
  input  logic [BCD_WIDTH-1:0]            conv_bcd
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic [IN_WIDTH-1:0] sel_value;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                grant_en;
  logic                capture_en;
  logic                sel_unchanged;
  logic                skip_q;

  rr_select #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_rr_select (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Pick the binary value slice of the requester the round-robin search selected.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) sel_value = req_value[i*IN_WIDTH +: IN_WIDTH];
    end
  end

`ifdef BCD_ARB_SKIP_UNCHANGED_EN
  logic [IN_WIDTH-1:0] last_val [N_REQ];
  logic [N_REQ-1:0]    last_valid;

  // Detect a request for a value this requester already has converted.
  always_comb begin
    sel_unchanged = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) sel_unchanged = last_valid[i] && (last_val[i] == sel_value);
    end
  end

  // Remember whether this grant skipped the converter, and record every real conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_q     <= 1'b0;
      last_valid <= '0;
      for (int i = 0; i < N_REQ; i++) last_val[i] <= '0;
    end else begin
      if (grant_en) skip_q <= sel_unchanged;
      if (capture_en && !skip_q) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_idx == IDX_W'(i)) begin
            last_val[i]   <= conv_in;
            last_valid[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign sel_unchanged = 1'b0;
  assign skip_q        = 1'b0;
`endif

  // Next-state logic; grant and capture strobes steer the datapath register block.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found && conv_idle) begin
          grant_en  = 1'b1;
          state_nxt = sel_unchanged ? S_CAPTURE : S_START;
        end
      end
      S_START:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!conv_idle)                              state_nxt = S_WAIT_DONE;
        else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) state_nxt = S_START;
      end
      S_WAIT_DONE: if (conv_idle) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        capture_en = 1'b1;
        state_nxt  = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Registered outputs, latched request, ack timeout counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conv_trigger <= 1'b0;
      conv_in      <= '0;
      done         <= '0;
      bcd_out      <= '0;
      busy         <= 1'b0;
      grant_idx    <= '0;
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
    end else begin
      conv_trigger <= (state_nxt == S_START);
      busy         <= (state_nxt != S_IDLE);
      done         <= '0;
      if (grant_en) begin
        grant_idx <= sel_idx;
        conv_in   <= sel_value;
      end
      if (state == S_WAIT_ACK && conv_idle)
        tmo_cnt <= (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) ? '0 : tmo_cnt + TMO_W'(1);
      else
        tmo_cnt <= '0;
      if (capture_en) begin
        rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_idx == IDX_W'(i)) begin
            done[i] <= 1'b1;
            if (!skip_q) bcd_out[i*BCD_WIDTH +: BCD_WIDTH] <= conv_bcd;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed testbench for bcd_conv_arbiter with a behavioural double-dabble converter.
// Honours BCD_ARB_SKIP_UNCHANGED_EN for the repeated-value scenario.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [63:0] req_value = '0;
  logic [1:0]  done;
  logic [63:0] bcd_out;
  logic        busy;
  logic [0:0]  grant_idx;
  logic        conv_trigger;
  logic [31:0] conv_in;
  logic        conv_idle = 1'b1;
  logic [31:0] conv_bcd = '0;

  int checks = 0;
  int failures = 0;

  int          conv_lat = 35;
  int          trig_count = 0;
  int          ignore_trig_at = -1;
  int          remain = 0;
  logic [31:0] held = '0;
  int          done_events[$];
  int          multi_done = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_value    (req_value),
    .done         (done),
    .bcd_out      (bcd_out),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .conv_trigger (conv_trigger),
    .conv_in      (conv_in),
    .conv_idle    (conv_idle),
    .conv_bcd     (conv_bcd)
  );

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Converter model: starts on a trigger while idle (unless told to ignore it), busy conv_lat cycles.
  always @(posedge clk) begin
    if (conv_trigger) begin
      trig_count <= trig_count + 1;
      if (conv_idle && trig_count != ignore_trig_at) begin
        conv_idle <= 1'b0;
        remain    <= conv_lat;
        held      <= conv_in;
      end
    end else if (!conv_idle) begin
      if (remain <= 1) begin
        conv_idle <= 1'b1;
        conv_bcd  <= to_bcd(held);
      end else begin
        remain <= remain - 1;
      end
    end
  end

  // Record which requester each done pulse belongs to, and any multi-bit done.
  always @(negedge clk) begin
    if (done[0]) done_events.push_back(0);
    if (done[1]) done_events.push_back(1);
    if (done == 2'b11) multi_done <= multi_done + 1;
  end

  task automatic apply_reset();
    @(negedge clk);
    req     = 2'b00;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int start;
    int n;
    reset_n = 1'b0;
    req = 2'b01;
    req_value[31:0] = 32'd1234;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, conv_trigger, grant_idx, conv_in, bcd_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0", {busy, done, conv_trigger, grant_idx, conv_in, bcd_out});
    end
    start = trig_count;
    reset_n = 1'b1;
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({conv_trigger, busy} !== 2'b11) begin
          failures++;
          $display("[TB] FAIL start_cycle: trigger/busy got %b expected 11", {conv_trigger, busy});
        end
      end
      if (done !== 2'b00) begin
        n = c;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (n != 39) begin
      failures++;
      $display("[TB] FAIL first_latency: got %0d cycles expected 39", n);
    end
    checks++;
    if (done !== 2'b01) begin
      failures++;
      $display("[TB] FAIL first_done: got %b expected 01", done);
    end
    checks++;
    if (bcd_out[31:0] !== 32'h00001234) begin
      failures++;
      $display("[TB] FAIL first_bcd: got %h expected 00001234", bcd_out[31:0]);
    end
    checks++;
    if (trig_count - start != 1) begin
      failures++;
      $display("[TB] FAIL first_triggers: got %0d expected 1", trig_count - start);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_drop: got %b expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 2'b00) begin
      failures++;
      $display("[TB] FAIL done_one_cycle: got %b expected 00", done);
    end
  endtask

  task automatic test_round_robin();
    int base;
    int multi0;
    int got;
    logic [0:0] exp_idx;
    apply_reset();
    base = done_events.size();
    multi0 = multi_done;
    req_value = {32'd99999999, 32'd7};
    req = 2'b11;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        got++;
        exp_idx = (got == 2) ? 1'b1 : 1'b0;
        checks++;
        if (grant_idx !== exp_idx) begin
          failures++;
          $display("[TB] FAIL rr_grant_idx: got %0d expected %0d", grant_idx, exp_idx);
        end
        if (got == 3) begin
          req = 2'b00;
          break;
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done_events.size() != base + 3) begin
      failures++;
      $display("[TB] FAIL rr_done_count: got %0d expected 3", done_events.size() - base);
    end else begin
      checks++;
      if ({done_events[base], done_events[base+1], done_events[base+2]} !== {32'd0, 32'd1, 32'd0}) begin
        failures++;
        $display("[TB] FAIL rr_order: got %0d,%0d,%0d expected 0,1,0",
                 done_events[base], done_events[base+1], done_events[base+2]);
      end
    end
    checks++;
    if (multi_done != multi0) begin
      failures++;
      $display("[TB] FAIL rr_multi_done: got %0d expected 0", multi_done - multi0);
    end
    checks++;
    if (bcd_out[63:32] !== 32'h99999999) begin
      failures++;
      $display("[TB] FAIL rr_slice1: got %h expected 99999999", bcd_out[63:32]);
    end
    checks++;
    if (bcd_out[31:0] !== 32'h00000007) begin
      failures++;
      $display("[TB] FAIL rr_slice0: got %h expected 00000007", bcd_out[31:0]);
    end
  endtask

  task automatic test_ack_timeout();
    int start;
    int tcnt;
    int t1;
    int t2;
    int seen;
    ignore_trig_at = trig_count;
    start = trig_count;
    req_value[31:0] = 32'd42;
    req = 2'b01;
    tcnt = 0;
    t1 = 0;
    t2 = 0;
    seen = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (conv_trigger) begin
        tcnt++;
        if (tcnt == 1) t1 = c;
        else if (tcnt == 2) t2 = c;
      end
      if (done !== 2'b00) begin
        seen = 1;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("[TB] FAIL ack_done: got %0d expected 1", seen);
    end
    checks++;
    if (trig_count - start != 2 || tcnt != 2) begin
      failures++;
      $display("[TB] FAIL ack_retrigger: got %0d expected 2", trig_count - start);
    end
    checks++;
    if (t2 - t1 != 5) begin
      failures++;
      $display("[TB] FAIL ack_gap: got %0d expected 5", t2 - t1);
    end
    checks++;
    if (bcd_out[31:0] !== 32'h00000042) begin
      failures++;
      $display("[TB] FAIL ack_bcd: got %h expected 00000042", bcd_out[31:0]);
    end
    ignore_trig_at = -1;
  endtask

  task automatic test_reset_mid_conv();
    int bad;
    int idle_back;
    int seen;
    @(negedge clk);
    req_value[31:0] = 32'd555;
    req = 2'b01;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy && !conv_idle) break;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, conv_trigger, grant_idx, conv_in, bcd_out} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got %0h expected 0", {busy, done, conv_trigger, grant_idx, conv_in, bcd_out});
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    idle_back = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (conv_idle) begin
        idle_back = 1;
        break;
      end
      if (conv_trigger || busy) bad++;
    end
    checks++;
    if (bad != 0 || idle_back != 1) begin
      failures++;
      $display("[TB] FAIL midreset_hold: got %0d active cycles (idle_back=%0d) expected 0 (1)", bad, idle_back);
    end
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        seen = 1;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (seen != 1 || bcd_out[31:0] !== 32'h00000555) begin
      failures++;
      $display("[TB] FAIL midreset_result: got %h (done=%0d) expected 00000555", bcd_out[31:0], seen);
    end
    checks++;
    if (bcd_out[63:32] !== 32'h00000000) begin
      failures++;
      $display("[TB] FAIL midreset_slice1: got %h expected 00000000", bcd_out[63:32]);
    end
  endtask

  task automatic test_value_change_and_drop();
    int seen;
    @(negedge clk);
    req_value[31:0] = 32'd5;
    req = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (conv_trigger) break;
    end
    req_value[31:0] = 32'd6;
    req = 2'b00;
    repeat (10) @(negedge clk);
    checks++;
    if (conv_in !== 32'd5) begin
      failures++;
      $display("[TB] FAIL hold_conv_in: got %0d expected 5", conv_in);
    end
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen != 1 || done !== 2'b01) begin
      failures++;
      $display("[TB] FAIL drop_done: got %b (seen=%0d) expected 01", done, seen);
    end
    checks++;
    if (bcd_out[31:0] !== 32'h00000005) begin
      failures++;
      $display("[TB] FAIL change_bcd: got %h expected 00000005", bcd_out[31:0]);
    end
  endtask

  task automatic test_repeat_value();
    int start;
    int n;
    @(negedge clk);
    req_value[31:0] = 32'd1234;
    req = 2'b01;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        req = 2'b00;
        break;
      end
    end
    repeat (2) @(negedge clk);
    start = trig_count;
    req = 2'b01;
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        n = c;
        req = 2'b00;
        break;
      end
    end
`ifdef BCD_ARB_SKIP_UNCHANGED_EN
    checks++;
    if (n != 2) begin
      failures++;
      $display("[TB] FAIL skip_latency: got %0d expected 2", n);
    end
    checks++;
    if (trig_count - start != 0) begin
      failures++;
      $display("[TB] FAIL skip_no_trigger: got %0d expected 0", trig_count - start);
    end
`else
    checks++;
    if (n != 39) begin
      failures++;
      $display("[TB] FAIL repeat_latency: got %0d expected 39", n);
    end
    checks++;
    if (trig_count - start != 1) begin
      failures++;
      $display("[TB] FAIL repeat_trigger: got %0d expected 1", trig_count - start);
    end
`endif
    checks++;
    if (bcd_out[31:0] !== 32'h00001234) begin
      failures++;
      $display("[TB] FAIL repeat_bcd: got %h expected 00001234", bcd_out[31:0]);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_ack_timeout();
    test_reset_mid_conv();
    test_value_change_and_drop();
    test_repeat_value();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one unsigned-to-BCD (double dabble) converter between N_REQ requesters, e.g. the event counter and a secondary statistic shown on the 7-segment mux.
- Round-robin arbitration. Drives the converter's trigger/in pair and watches its idle/bcd pair.
- Holds one registered BCD result per requester and flags each completed conversion with a done pulse.
- Sits between the counter/FSM logic and the converter; ss_mux reads bcd_out slices.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- IN_WIDTH, 32, unsigned binary width per requester; equals converter input width
- BCD_WIDTH, 32, BCD result width per requester; equals converter output width
- ACK_TIMEOUT, 4, cycles to wait for conv_idle to fall after trigger before re-triggering

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request; bit i set means requester i wants a conversion
- req_value  in  N_REQ*IN_WIDTH  binary value; slice i belongs to requester i
- done  out  N_REQ  one-cycle pulse; bit i set means bcd_out slice i was updated this cycle
- bcd_out  out  N_REQ*BCD_WIDTH  last converted result per requester
- busy  out  1  high in every state except S_IDLE
- grant_idx  out  clog2(N_REQ) (min 1)  index of the requester being served; valid while busy
- conv_trigger  out  1  start pulse to converter
- conv_in  out  IN_WIDTH  value presented to converter
- conv_idle  in  1  converter idle flag
- conv_bcd  in  BCD_WIDTH  converter result, valid while conv_idle=1 after a conversion

Behaviour:
- Reset (async assert, sync release): state S_IDLE. conv_trigger=0, conv_in=0, done=0, bcd_out=0, busy=0, grant_idx=0, rr pointer=0, timeout counter=0.
- All outputs are registered.
- FSM states:
  - S_IDLE: if any req bit is set and conv_idle=1, pick the first set bit searching upward from the rr pointer (wrapping). Latch grant_idx and conv_in from that req_value slice, then go to S_START. If conv_idle=0 (e.g. converter still running after a reset), stay in S_IDLE.
  - S_START: conv_trigger=1 for exactly this one cycle. Go to S_WAIT_ACK.
  - S_WAIT_ACK: if conv_idle=0, go to S_WAIT_DONE. Otherwise increment the timeout counter; when it reaches ACK_TIMEOUT, clear it and return to S_START (re-trigger).
  - S_WAIT_DONE: when conv_idle=1, go to S_CAPTURE.
  - S_CAPTURE: bcd_out[grant_idx] <= conv_bcd and done[grant_idx] <= 1. The update and pulse are visible the cycle after S_CAPTURE. rr pointer <= grant_idx+1 (mod N_REQ). Go to S_IDLE.
- conv_in is held stable from S_IDLE exit until S_CAPTURE exit. Changes on req_value during a conversion are ignored.
- If the granted req drops mid-conversion, the conversion still completes: bcd_out is updated and done pulses.
- Simultaneous requests are served round-robin. With N_REQ=2 and both req bits held, grants alternate 0,1,0,1...
- Best-case latency from req (conv_idle=1) to done: 4 cycles plus converter busy time.
- Back-to-back: at least 1 cycle in S_IDLE between conversions.
- done is never asserted on more than one bit per cycle.

Optional Feature:
- Macro BCD_ARB_SKIP_UNCHANGED_EN.
- Defined:
  - Per-requester registers hold the last converted value plus a valid bit; all are cleared on reset.
  - In S_IDLE, if the selected requester's req_value equals its stored value and valid=1, go directly to S_CAPTURE. The converter is not triggered, bcd_out is unchanged, and done still pulses.
  - The stored value and valid bit are updated at every real capture.
- Not defined: every grant triggers the converter; no per-requester value storage.

Decomposition:
- Package bcd_arb_pkg:
  - state localparams S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_CAPTURE, one-hot 5 bits
  - default widths
  - idx-width helper function
- Sub-module rr_select: combinational round-robin first-set search. Inputs are the req vector and pointer; outputs are the index and a found flag.

Test Plan:
- Reset with req=2'b01, value0=1234, converter model at 35 cycles: conv_trigger pulses once, bcd_out slice0=32'h00001234, done=2'b01 for one cycle, busy drops.
- req=2'b11, value0=7, value1=99999999, held: grant order 0,1,0. Slice1=32'h99999999 and slice0=32'h00000007; done never 2'b11.
- Converter model ignores the first trigger: conv_trigger re-pulses after 4 cycles in S_WAIT_ACK, then completes normally.
- reset_n asserted low while in S_WAIT_DONE: all outputs are 0 immediately. After release with conv_idle=0, no trigger until conv_idle=1.
- Change value0 from 5 to 6 during conversion: result is BCD 5. req0 dropped mid-conversion: done still pulses.
- With BCD_ARB_SKIP_UNCHANGED_EN, re-request value0=1234: done pulses 2 cycles after grant, no conv_trigger, bcd_out unchanged.
